// File: rtl/jt12_eg_phase_pkg.sv
// Shared phase codes, rate/level constants and the per-slot ring record.
// Pure definitions: no latency, no flow control.
package jt12_eg_phase_pkg;

   typedef enum logic [1:0] {
      ST_ATTACK  = 2'd0,
      ST_DECAY   = 2'd1,
      ST_SUSTAIN = 2'd2,
      ST_RELEASE = 2'd3
   } phase_t;

   localparam logic [4:0] AR_INSTANT = 5'd31;
   localparam logic [3:0] SL_MAX     = 4'd15;

   typedef struct packed {
      phase_t phase;
      logic   keyon_prev;
   } slot_t;

   // The top sustain level maps to the 0x3E0 ceiling rather than 0x1E0.
   function automatic logic [9:0] sustain_thr(input logic [3:0] sl);
      return {(sl == SL_MAX) ? 5'h1F : {1'b0, sl}, 5'b0};
   endfunction

endpackage

// File: rtl/jt12_eg_phase_if.sv
// Stage II slot inputs and stage III phase outputs of the EG phase tracker.
// Strobed by clk_en; no backpressure, one slot per strobe.
interface jt12_eg_phase_if;
   logic       clk_en;
   logic       keyon_II;
   logic [9:0] attn_II;
   logic [4:0] ar_II;
   logic [3:0] sl_II;
   logic [1:0] state_III;
   logic       keyon_now_III;
   logic       keyoff_now_III;
   logic       attn_zero_III;
   logic       pg_rst_III;

   modport master (
      output clk_en, keyon_II, attn_II, ar_II, sl_II,
      input  state_III, keyon_now_III, keyoff_now_III, attn_zero_III, pg_rst_III
   );

   modport slave (
      input  clk_en, keyon_II, attn_II, ar_II, sl_II,
      output state_III, keyon_now_III, keyoff_now_III, attn_zero_III, pg_rst_III
   );
endinterface

// File: rtl/jt12_eg_phase_sh.sv
// clk_en-gated shift register for the time-multiplexed slot rings.
// Latency STAGES strobes; holds while clk_en is low.
module jt12_sh #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 24
) (
   input  logic             clk,
   input  logic             clk_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] drop
);

   logic [STAGES-1:0][WIDTH-1:0] bits;

   always_ff @(posedge clk) begin
      if (clk_en) bits <= {bits[STAGES-2:0], din};
   end

   assign drop = bits[STAGES-1];

endmodule

// File: rtl/jt12_eg_phase.sv
// Per-slot ATTACK/DECAY/SUSTAIN/RELEASE tracker over a SLOTS-deep state ring.
// Stage II inputs appear registered at stage III on the next clk_en; holds while clk_en is low.
module jt12_eg_phase
   import jt12_eg_phase_pkg::*;
#(
   parameter int SLOTS = 24
) (
   input logic            clk,
   input logic            rst,
   jt12_eg_phase_if.slave bus
);

   slot_t      slot_q, slot_next, ring_out;
   logic [2:0] ring_bits;
   logic       rise, fall, zero_next;
   logic       keyon_now_q, keyoff_now_q, attn_zero_q;

   // slot_q is both the stage III output and the last ring stage.
   jt12_sh #(.WIDTH(3), .STAGES(SLOTS-1)) u_sh (
      .clk    (clk),
      .clk_en (bus.clk_en),
      .din    (slot_q),
      .drop   (ring_bits)
   );

   assign ring_out = slot_t'(ring_bits);

   always_comb begin
      rise                 = bus.keyon_II & ~ring_out.keyon_prev;
      fall                 = ~bus.keyon_II & ring_out.keyon_prev;
      zero_next            = 1'b0;
      slot_next.keyon_prev = bus.keyon_II;
      slot_next.phase      = ring_out.phase;
      if (rise) begin
         if (bus.ar_II == AR_INSTANT) begin
            slot_next.phase = ST_DECAY;
            zero_next       = 1'b1;
         end else begin
            slot_next.phase = ST_ATTACK;
         end
      end else if (fall) begin
         slot_next.phase = ST_RELEASE;
      end else if (ring_out.phase == ST_ATTACK && bus.attn_II == 10'd0) begin
         slot_next.phase = ST_DECAY;
      end else if (ring_out.phase == ST_DECAY && bus.attn_II >= sustain_thr(bus.sl_II)) begin
         slot_next.phase = ST_SUSTAIN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q       <= '{phase: ST_RELEASE, keyon_prev: 1'b0};
         keyon_now_q  <= 1'b0;
         keyoff_now_q <= 1'b0;
         attn_zero_q  <= 1'b0;
      end else if (bus.clk_en) begin
         slot_q       <= slot_next;
         keyon_now_q  <= rise;
         keyoff_now_q <= fall;
         attn_zero_q  <= zero_next;
      end
   end

   assign bus.state_III      = slot_q.phase;
   assign bus.keyon_now_III  = keyon_now_q;
   assign bus.keyoff_now_III = keyoff_now_q;
   assign bus.attn_zero_III  = attn_zero_q;
   assign bus.pg_rst_III     = keyon_now_q;

endmodule

// File: tb/tb_jt12_eg_phase.sv
// Random and directed slot traffic checked against an array-per-slot envelope phase model.
module tb_jt12_eg_phase;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   jt12_eg_phase_if bus();
   jt12_eg_phase dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   int m_phase [24];
   int m_prev  [24];
   int e_state, e_kn, e_ko, e_az;

   bit pin    [24];
   bit kon    [24];
   bit rst_at [24];
   int attn   [24];
   int ar     [24];
   int sl     [24];
   int o_state[24], o_kn[24], o_ko[24], o_az[24], o_pg[24];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic pulse(input int s, input bit r, input bit k, input int a, input int rr, input int l);
      int np, thr;
      bit rise, fall, az;
      @(negedge clk);
      rst          = r;
      bus.clk_en   = 1'b1;
      bus.keyon_II = k;
      bus.attn_II  = a[9:0];
      bus.ar_II    = rr[4:0];
      bus.sl_II    = l[3:0];
      @(posedge clk);
      #1;
      bus.clk_en = 1'b0;
      rst        = 1'b0;
      if (r) begin
         e_state = 3; e_kn = 0; e_ko = 0; e_az = 0;
         m_phase[s] = 3; m_prev[s] = 0;
      end else begin
         rise = k && (m_prev[s] == 0);
         fall = !k && (m_prev[s] == 1);
         thr  = (l == 15) ? 31 * 32 : l * 32;
         np   = m_phase[s];
         az   = 1'b0;
         if (rise) begin
            if (rr == 31) begin np = 1; az = 1'b1; end
            else np = 0;
         end else if (fall) np = 3;
         else if (np == 0 && a == 0) np = 1;
         else if (np == 1 && a >= thr) np = 2;
         m_phase[s] = np;
         m_prev[s]  = k;
         e_state = np; e_kn = rise; e_ko = fall; e_az = az;
      end
      chk($sformatf("state s%0d", s),      16'(bus.state_III),      16'(e_state));
      chk($sformatf("keyon_now s%0d", s),  16'(bus.keyon_now_III),  16'(e_kn));
      chk($sformatf("keyoff_now s%0d", s), 16'(bus.keyoff_now_III), 16'(e_ko));
      chk($sformatf("attn_zero s%0d", s),  16'(bus.attn_zero_III),  16'(e_az));
      chk($sformatf("pg_rst s%0d", s),     16'(bus.pg_rst_III),     16'(e_kn));
      o_state[s] = bus.state_III;
      o_kn[s]    = bus.keyon_now_III;
      o_ko[s]    = bus.keyoff_now_III;
      o_az[s]    = bus.attn_zero_III;
      o_pg[s]    = bus.pg_rst_III;
   endtask

   task automatic round();
      for (int s = 0; s < 24; s++) begin
         if (!pin[s]) begin
            if ($urandom_range(3) == 0) kon[s] = !kon[s];
            sl[s] = $urandom_range(15);
            ar[s] = ($urandom_range(3) == 0) ? 31 : $urandom_range(30);
            case ($urandom_range(3))
               0:       attn[s] = 0;
               1:       attn[s] = $urandom_range(1023);
               2:       attn[s] = (sl[s] == 15) ? 992 : sl[s] * 32;
               default: attn[s] = (sl[s] == 15) ? 991 : sl[s] * 32 + 31;
            endcase
            rst_at[s] = ($urandom_range(63) == 0);
         end
         pulse(s, rst_at[s], kon[s], attn[s], ar[s], sl[s]);
         rst_at[s] = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
      chk("frozen state",      16'(bus.state_III),      16'(e_state));
      chk("frozen keyon_now",  16'(bus.keyon_now_III),  16'(e_kn));
      chk("frozen keyoff_now", 16'(bus.keyoff_now_III), 16'(e_ko));
      chk("frozen attn_zero",  16'(bus.attn_zero_III),  16'(e_az));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.clk_en = 1'b0; bus.keyon_II = 1'b0; bus.attn_II = '0; bus.ar_II = '0; bus.sl_II = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset state",     16'(bus.state_III),      16'd3);
      chk("reset keyon_now", 16'(bus.keyon_now_III),  16'd0);
      chk("reset keyoff",    16'(bus.keyoff_now_III), 16'd0);
      chk("reset pg_rst",    16'(bus.pg_rst_III),     16'd0);
      rst = 1'b0;

      for (int s = 0; s < 24; s++) begin
         pin[s] = 1'b1; kon[s] = 1'b0; attn[s] = 1023; ar[s] = 0; sl[s] = 0; rst_at[s] = 1'b1;
      end
      round();
      round();
      round();
      chk("idle s0 state",  16'(o_state[0]),  16'd3);
      chk("idle s23 state", 16'(o_state[23]), 16'd3);

      for (int s = 0; s < 24; s++) pin[s] = (s == 5 || s == 9);
      kon[5] = 1'b1; ar[5] = 20; attn[5] = 'h200; sl[5] = 4;
      kon[9] = 1'b0; ar[9] = 0;  attn[9] = 'h100; sl[9] = 0;
      round();
      chk("s5 attack state", 16'(o_state[5]), 16'd0);
      chk("s5 keyon_now",    16'(o_kn[5]),    16'd1);
      chk("s5 pg_rst",       16'(o_pg[5]),    16'd1);

      attn[5] = 0;
      kon[9] = 1'b1; ar[9] = 31; sl[9] = 15; attn[9] = 'h100;
      round();
      chk("s5 attack->decay", 16'(o_state[5]), 16'd1);
      chk("s9 instant state", 16'(o_state[9]), 16'd1);
      chk("s9 attn_zero",     16'(o_az[9]),    16'd1);
      chk("s9 keyon_now",     16'(o_kn[9]),    16'd1);

      attn[5] = 'h07F; attn[9] = 'h3DF;
      round();
      chk("s5 below thr",   16'(o_state[5]), 16'd1);
      chk("s9 below thr15", 16'(o_state[9]), 16'd1);
      chk("s9 az cleared",  16'(o_az[9]),    16'd0);

      attn[5] = 'h080; attn[9] = 'h3E0;
      round();
      chk("s5 at thr", 16'(o_state[5]), 16'd2);
      chk("s9 at thr15", 16'(o_state[9]), 16'd2);

      idle(10);

      kon[9] = 1'b0;
      round();
      chk("s9 release",    16'(o_state[9]), 16'd3);
      chk("s9 keyoff_now", 16'(o_ko[9]),    16'd1);
      chk("s5 sustain held", 16'(o_state[5]), 16'd2);

      kon[9] = 1'b1; ar[9] = 10; attn[9] = 'h300;
      round();
      chk("s9 re-attack",   16'(o_state[9]), 16'd0);
      chk("s9 re-keyon",    16'(o_kn[9]),    16'd1);

      kon[9] = 1'b0;
      round();
      kon[9] = 1'b1; rst_at[9] = 1'b1;
      round();
      chk("s9 rst over rise",  16'(o_state[9]), 16'd3);
      chk("s9 rst keyon_now",  16'(o_kn[9]),    16'd0);
      chk("s9 rst pg_rst",     16'(o_pg[9]),    16'd0);
      round();
      chk("s9 rise after rst", 16'(o_state[9]), 16'd0);

      for (int s = 0; s < 24; s++) pin[s] = 1'b0;
      for (int r = 0; r < 25; r++) begin
         round();
         if (r % 5 == 4) idle($urandom_range(12, 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
